// File: rtl/uart_pkg.sv
// Shared UART definitions, used by the receiver and the matching transmitter.
//   DATA_BITS            : payload bits per frame (8N1)
//   CLKS_PER_BIT_DEFAULT : default bit period in clocks (50 MHz / 115200)
//   rx_state_e           : receiver FSM state encoding
package uart_pkg;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop bit synchroniser for an asynchronous input.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, all stages reset to 1
//   d_i    : asynchronous input
//   q_o    : synchronised output, Stages clocks of latency
module sync_2ff #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/uart_rxd.sv
// UART 8N1 receiver with mid-bit sampling and start-bit glitch rejection.
//   iCLOCK    : system clock, rising edge
//   iNRESET   : asynchronous active-low reset
//   iRX       : serial line, idle high, asynchronous
//   oRXDATA   : last correctly framed byte (LSB received first)
//   oRXVALID  : one-cycle strobe, oRXDATA updated
//   oRXBUSY   : high whenever the FSM is not idle
//   oFRAMEERR : one-cycle strobe, stop bit sampled low
module uart_rxd
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       iCLOCK,
  input  logic       iNRESET,
  input  logic       iRX,
  output logic [7:0] oRXDATA,
  output logic       oRXVALID,
  output logic       oRXBUSY,
  output logic       oFRAMEERR
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] HalfTick = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullTick = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] LastBit  = BitW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BitW-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 half_tick, full_tick;

  sync_2ff #(
    .Stages (SYNC_STAGES)
  ) u_sync (
    .clk_i  (iCLOCK),
    .rst_ni (iNRESET),
    .d_i    (iRX),
    .q_o    (rx_s)
  );

  assign half_tick = (cnt_q == HalfTick);
  assign full_tick = (cnt_q == FullTick);

  // State register
  always_ff @(posedge iCLOCK or negedge iNRESET) begin
    if (!iNRESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (!rx_s) state_d = StStart;
      // Line must still be low at mid start bit, otherwise it was a glitch
      StStart:    if (half_tick) state_d = rx_s ? StIdle : StData;
      StData:     if (full_tick && (bit_idx_q == LastBit)) state_d = StStop;
      // Leaving at mid stop bit leaves half a bit to catch a back-to-back start
      StStop:     if (full_tick) state_d = rx_s ? StIdle : StWaitIdle;
      // Hold off through a break so it cannot start phantom frames
      StWaitIdle: if (rx_s) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Datapath and output next-state logic
  always_comb begin
    cnt_d     = cnt_q + CntW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    // Restart bit timing on each state entry and on every bit boundary in DATA
    if ((state_d != state_q) || full_tick || (state_q == StIdle) ||
        (state_q == StWaitIdle)) begin
      cnt_d = '0;
    end

    unique case (state_q)
      StStart: begin
        if (half_tick && !rx_s) bit_idx_d = '0;
      end
      StData: begin
        if (full_tick) begin
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + BitW'(1);
        end
      end
      StStop: begin
        if (full_tick) begin
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge iNRESET) begin
    if (!iNRESET) begin
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign oRXDATA   = data_q;
  assign oRXVALID  = valid_q;
  assign oFRAMEERR = ferr_q;
  assign oRXBUSY   = (state_q != StIdle);

endmodule
